cva6_ypb_obi_arbiter: RTL

Shares one OBI master port between the pipeline's YPB requesters (fetch, load, store, AMO, MMU PTW, ZCMT) inside the pipeline-only memory adapter subsystem. Selection is round-robin and is locked while a request waits for grant, so the OBI request stays stable. The ID of each granted requester is recorded in an in-order outstanding FIFO. Each OBI response is routed back to the requester at the FIFO head.

---
 rtl/cva6_ypb_obi_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cva6_ypb_obi_arbiter.sv
// Round-robin arbiter sharing one OBI master port between the YPB requesters.
// The granted requester IDs are kept in an in-order FIFO so each response returns to its issuer.
module cva6_ypb_obi_arbiter #(
  parameter int unsigned NumReq         = 6,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned IdxW           = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]      req_addr_i,
  input  logic [NumReq-1:0]                     req_we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    req_be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      req_wdata_i,
  output logic [NumReq-1:0]                     rsp_valid_o,
  output logic [DataWidth-1:0]                  rsp_rdata_o,
  output logic                                  rsp_err_o,
  output logic                                  obi_req_o,
  input  logic                                  obi_gnt_i,
  output logic [AddrWidth-1:0]                  obi_addr_o,
  output logic                                  obi_we_o,
  output logic [DataWidth/8-1:0]                obi_be_o,
  output logic [DataWidth-1:0]                  obi_wdata_o,
  input  logic                                  obi_rvalid_i,
  input  logic [DataWidth-1:0]                  obi_rdata_i,
  input  logic                                  obi_err_i,
  output logic                                  busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic                                lock_q, lock_d;
  logic [IdxW-1:0]                     lock_idx_q, lock_idx_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [PtrW-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MaxOutstanding-1:0][IdxW-1:0] fifo_q, fifo_d;

  logic [IdxW-1:0] sel, cand;
  logic            found, full, hs, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A held selection wins over the scan so a stalled A-channel stays stable.
  always_comb begin
    sel   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = lock_idx_q;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        cand = IdxW'((int'(rr_ptr_q) + k) % NumReq);
        if (!found && req_valid_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Full is taken from the registered count only: no rvalid/gnt to req path.
  assign full        = (cnt_q == CntW'(MaxOutstanding));
  assign obi_req_o   = req_valid_i[sel] & ~full & rst_ni;
  assign obi_addr_o  = req_addr_i[sel];
  assign obi_we_o    = req_we_i[sel];
  assign obi_be_o    = req_be_i[sel];
  assign obi_wdata_o = req_wdata_i[sel];
  assign hs          = obi_req_o & obi_gnt_i;
  assign pop         = obi_rvalid_i & (cnt_q != '0) & rst_ni;
  assign rsp_rdata_o = obi_rdata_i;
  assign rsp_err_o   = obi_err_i;
  assign busy_o      = (cnt_q != '0) | obi_req_o;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (hs)  req_ready_o[sel] = 1'b1;
    if (pop) rsp_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_d     = fifo_q;
    if (hs) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_ptr_d         = (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
      lock_d           = 1'b0;
    end else if (obi_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (hs && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (!hs && pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

`ifndef SYNTHESIS
  a_lock_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[lock_idx_q])
    else $error("requester %0d dropped valid before accept", lock_idx_q);
  a_lock_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && $past(obi_req_o)) |->
      ($stable(obi_addr_o) && $stable(obi_we_o) && $stable(obi_be_o) && $stable(obi_wdata_o)))
    else $error("requester %0d changed payload before accept", lock_idx_q);
  a_unexp_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_rvalid_i |-> (cnt_q != '0))
    else $warning("unexpected OBI response dropped");
`endif

endmodule
